// File: rtl/hw_ctrl_seq.sv
// Hardwired control unit for the teaching CPU with its own beat sequencer.
// It runs, single-steps or halts, and counts the instructions it retires.
module hw_ctrl_seq #(
    parameter int OPC_W = 4,
    parameter int EN_OR = 1,
    parameter int CNT_W = 16
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             start,
    input  logic             step_en,
    input  logic [OPC_W-1:0] ir,
    input  logic             c,
    input  logic             z,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] icount,
    output logic             lir,
    output logic             pcinc,
    output logic             drw,
    output logic             ldz,
    output logic             ldc,
    output logic             cin,
    output logic             m,
    output logic             abus,
    output logic             mbus,
    output logic             lar,
    output logic             lpc,
    output logic             pcadd,
    output logic             memw,
    output logic [3:0]       s
);

    // state  | meaning
    // IDLE   | halted, waiting for start
    // RUN_W1 | fetch beat
    // RUN_W2 | execute beat (last beat unless LD/ST)
    // RUN_W3 | memory beat of LD/ST
    typedef enum logic [1:0] {IDLE, RUN_W1, RUN_W2, RUN_W3} state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_STP = 4'b1110;

    state_t     state;
    logic [3:0] opc;
    logic       is_long;
    logic       last_beat;
    logic       halt_req;

    assign opc = ir[OPC_W-1 -: 4];

    generate
        if (OPC_W > 4) begin : g_ir_low
            logic unused_ir_low;
            assign unused_ir_low = ^ir[OPC_W-5:0];
        end
    endgenerate

    assign is_long   = (opc == OP_LD) || (opc == OP_ST);
    assign last_beat = (state == RUN_W3) || ((state == RUN_W2) && !is_long);
    assign halt_req  = (opc == OP_STP) || step_en;

    always_ff @(posedge t3) begin
        if (!clr) begin
            state   <= IDLE;
            w1      <= 1'b0;
            w2      <= 1'b0;
            w3      <= 1'b0;
            running <= 1'b0;
            icount  <= '0;
        end else if (last_beat) begin
            icount  <= icount + CNT_W'(1);
            state   <= halt_req ? IDLE : RUN_W1;
            w1      <= !halt_req;
            w2      <= 1'b0;
            w3      <= 1'b0;
            running <= !halt_req;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN_W1;
                        w1      <= 1'b1;
                        running <= 1'b1;
                    end
                end
                RUN_W1: begin
                    state <= RUN_W2;
                    w1    <= 1'b0;
                    w2    <= 1'b1;
                end
                RUN_W2: begin
                    state <= RUN_W3;
                    w2    <= 1'b0;
                    w3    <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    w1      <= 1'b0;
                    w2      <= 1'b0;
                    w3      <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Controls follow the registered beat, so they are all low in IDLE.
    always_comb begin
        lir   = 1'b0;
        pcinc = 1'b0;
        drw   = 1'b0;
        ldz   = 1'b0;
        ldc   = 1'b0;
        cin   = 1'b0;
        m     = 1'b0;
        abus  = 1'b0;
        mbus  = 1'b0;
        lar   = 1'b0;
        lpc   = 1'b0;
        pcadd = 1'b0;
        memw  = 1'b0;
        s     = 4'b0000;
        if (w1) begin
            lir   = 1'b1;
            pcinc = 1'b1;
        end
        if (w2) begin
            case (opc)
                OP_ADD: begin s = 4'b1001; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                OP_SUB: begin s = 4'b0110; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                OP_AND: begin s = 4'b1011; m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
                OP_INC: begin s = 4'b0000; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                OP_LD:  begin s = 4'b1010; m = 1'b1; abus = 1'b1; lar = 1'b1; end
                OP_ST:  begin s = 4'b1111; m = 1'b1; abus = 1'b1; lar = 1'b1; end
                OP_JC:  pcadd = c;
                OP_JZ:  pcadd = z;
                OP_JMP: begin s = 4'b1111; m = 1'b1; abus = 1'b1; lpc = 1'b1; end
                OP_XOR: begin s = 4'b0110; m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
                OP_DEC: begin s = 4'b1111; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                OP_OR: begin
                    if (EN_OR != 0) begin
                        s = 4'b1110; m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w3) begin
            case (opc)
                OP_LD:   begin mbus = 1'b1; drw = 1'b1; end
                OP_ST:   begin s = 4'b1010; m = 1'b1; abus = 1'b1; memw = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// Bench for hw_ctrl_seq: two instances (default, and OPC_W=8/EN_OR=0/CNT_W=4)
// checked every cycle against an instruction-level model plus directed literals.
module tb_hw_ctrl_seq;

    localparam logic [16:0] LIR   = 17'h10000;
    localparam logic [16:0] PCINC = 17'h08000;
    localparam logic [16:0] DRW   = 17'h04000;
    localparam logic [16:0] LDZ   = 17'h02000;
    localparam logic [16:0] LDC   = 17'h01000;
    localparam logic [16:0] CIN   = 17'h00800;
    localparam logic [16:0] M     = 17'h00400;
    localparam logic [16:0] ABUS  = 17'h00200;
    localparam logic [16:0] MBUS  = 17'h00100;
    localparam logic [16:0] LAR   = 17'h00080;
    localparam logic [16:0] LPC   = 17'h00040;
    localparam logic [16:0] PCADD = 17'h00020;
    localparam logic [16:0] MEMW  = 17'h00010;

    logic       t3 = 1'b0;
    logic       clr, start, step_en, c, z;
    logic [3:0] ir_a;
    logic [7:0] ir_b;

    logic        w1_a, w2_a, w3_a, running_a;
    logic [15:0] icount_a;
    logic        lir_a, pcinc_a, drw_a, ldz_a, ldc_a, cin_a, m_a, abus_a, mbus_a, lar_a, lpc_a, pcadd_a, memw_a;
    logic [3:0]  s_a;
    logic        w1_b, w2_b, w3_b, running_b;
    logic [3:0]  icount_b;
    logic        lir_b, pcinc_b, drw_b, ldz_b, ldc_b, cin_b, m_b, abus_b, mbus_b, lar_b, lpc_b, pcadd_b, memw_b;
    logic [3:0]  s_b;

    int tests = 0;
    int fails = 0;

    assign ir_b = {ir_a, 4'b1010};

    always #5 t3 = ~t3;

    hw_ctrl_seq #(.OPC_W(4), .EN_OR(1), .CNT_W(16)) dut_a (
        .t3(t3), .clr(clr), .start(start), .step_en(step_en), .ir(ir_a), .c(c), .z(z),
        .w1(w1_a), .w2(w2_a), .w3(w3_a), .running(running_a), .icount(icount_a),
        .lir(lir_a), .pcinc(pcinc_a), .drw(drw_a), .ldz(ldz_a), .ldc(ldc_a), .cin(cin_a),
        .m(m_a), .abus(abus_a), .mbus(mbus_a), .lar(lar_a), .lpc(lpc_a), .pcadd(pcadd_a),
        .memw(memw_a), .s(s_a));

    hw_ctrl_seq #(.OPC_W(8), .EN_OR(0), .CNT_W(4)) dut_b (
        .t3(t3), .clr(clr), .start(start), .step_en(step_en), .ir(ir_b), .c(c), .z(z),
        .w1(w1_b), .w2(w2_b), .w3(w3_b), .running(running_b), .icount(icount_b),
        .lir(lir_b), .pcinc(pcinc_b), .drw(drw_b), .ldz(ldz_b), .ldc(ldc_b), .cin(cin_b),
        .m(m_b), .abus(abus_b), .mbus(mbus_b), .lar(lar_b), .lpc(lpc_b), .pcadd(pcadd_b),
        .memw(memw_b), .s(s_b));

    logic [16:0] ctl_a, ctl_b;
    assign ctl_a = {lir_a, pcinc_a, drw_a, ldz_a, ldc_a, cin_a, m_a, abus_a, mbus_a,
                    lar_a, lpc_a, pcadd_a, memw_a, s_a};
    assign ctl_b = {lir_b, pcinc_b, drw_b, ldz_b, ldc_b, cin_b, m_b, abus_b, mbus_b,
                    lar_b, lpc_b, pcadd_b, memw_b, s_b};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-table view of the controls for a given beat number (0 = none).
    function automatic logic [16:0] exp_ctl(input int beat, input logic [3:0] op,
                                            input logic cf, input logic zf, input bit en_or);
        logic [16:0] v;
        v = 17'h0;
        if (beat == 1) v = LIR | PCINC;
        else if (beat == 2) begin
            case (op)
                4'd1:  v = ABUS | DRW | LDZ | LDC | CIN | 17'h9;
                4'd2:  v = ABUS | DRW | LDZ | LDC | 17'h6;
                4'd3:  v = M | ABUS | DRW | LDZ | 17'hB;
                4'd4:  v = ABUS | DRW | LDZ | LDC;
                4'd5:  v = M | ABUS | LAR | 17'hA;
                4'd6:  v = M | ABUS | LAR | 17'hF;
                4'd7:  v = cf ? PCADD : 17'h0;
                4'd8:  v = zf ? PCADD : 17'h0;
                4'd9:  v = M | ABUS | LPC | 17'hF;
                4'd10: v = M | ABUS | DRW | LDZ | 17'h6;
                4'd11: v = CIN | ABUS | DRW | LDZ | LDC | 17'hF;
                4'd12: v = en_or ? (M | ABUS | DRW | LDZ | 17'hE) : 17'h0;
                default: v = 17'h0;
            endcase
        end else if (beat == 3) begin
            if (op == 4'd5) v = MBUS | DRW;
            else if (op == 4'd6) v = M | ABUS | MEMW | 17'hA;
        end
        return v;
    endfunction

    // Model: which beat of the current instruction is showing, and how many retired.
    int m_beat = 0;
    int m_cnt  = 0;
    bit armed  = 1'b0;

    always @(posedge t3) begin
        if (clr === 1'b0) begin
            m_beat = 0;
            m_cnt  = 0;
            armed  = 1'b1;
        end else if (armed) begin
            if (m_beat == 0) m_beat = start ? 1 : 0;
            else begin
                int len;
                len = (ir_a == 4'd5 || ir_a == 4'd6) ? 3 : 2;
                if (m_beat == len) begin
                    m_cnt++;
                    m_beat = (ir_a == 4'hE || step_en) ? 0 : 1;
                end else m_beat++;
            end
        end
    end

    always @(negedge t3) begin
        if (armed) begin
            chk("beats_a", {w1_a, w2_a, w3_a, running_a},
                {m_beat == 1, m_beat == 2, m_beat == 3, m_beat != 0});
            chk("beats_b", {w1_b, w2_b, w3_b, running_b},
                {m_beat == 1, m_beat == 2, m_beat == 3, m_beat != 0});
            chk("ctl_a", ctl_a, exp_ctl(m_beat, ir_a, c, z, 1'b1));
            chk("ctl_b", ctl_b, exp_ctl(m_beat, ir_a, c, z, 1'b0));
            chk("icount_a", icount_a, m_cnt % 65536);
            chk("icount_b", icount_b, m_cnt % 16);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge t3);
        #2;
    endtask

    task automatic issue(input logic [3:0] op);
        ir_a  = op;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [3:0] prog [6] = '{4'd6, 4'd1, 4'd5, 4'd10, 4'd11, 4'hE};
    logic [3:0] br_op [4] = '{4'd7, 4'd7, 4'd8, 4'd8};
    logic       br_f  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        clr = 1'b0; start = 1'b0; step_en = 1'b0; c = 1'b0; z = 1'b0; ir_a = 4'd0;
        tick(2);
        chk("reset_icount", icount_a, 0);
        chk("reset_running", running_a, 0);
        clr = 1'b1;

        // ADD: start latency, then continues into a STP
        issue(4'd1);
        chk("add_w1", ctl_a, LIR | PCINC);
        tick();
        chk("add_w2", ctl_a, 17'b0_0_1_1_1_1_0_1_0_0_0_0_0_1001);
        tick();
        chk("add_next_w1", w1_a, 1);
        chk("add_icount", icount_a, 1);
        ir_a = 4'hE;
        tick(2);
        chk("stp_halt", running_a, 0);
        chk("stp_icount", icount_a, 2);

        // reset in W2 of ADD aborts it
        issue(4'd1);
        tick();
        clr = 1'b0;
        tick(2);
        chk("midreset_icount", icount_a, 0);
        chk("midreset_beats", {w1_a, w2_a, w3_a, running_a}, 0);
        chk("midreset_ctl", ctl_a, 0);
        clr = 1'b1;

        // long instructions with single-step
        step_en = 1'b1;
        issue(4'd6);
        tick();
        chk("st_w2", ctl_a, M | ABUS | LAR | 17'hF);
        tick();
        chk("st_w3", ctl_a, M | ABUS | MEMW | 17'hA);
        chk("st_w3_icount", icount_a, 0);
        tick();
        chk("st_icount", icount_a, 1);
        chk("st_halt", running_a, 0);
        issue(4'd5);
        tick(2);
        chk("ld_w3", ctl_a, MBUS | DRW);
        tick();

        // conditional branches; the other flag is set opposite to catch mix-ups
        for (int i = 0; i < 4; i++) begin
            if (br_op[i] == 4'd7) begin c = br_f[i]; z = !br_f[i]; end
            else begin z = br_f[i]; c = !br_f[i]; end
            issue(br_op[i]);
            tick();
            chk("branch_pcadd", pcadd_a, br_f[i]);
            tick();
        end

        // OR enabled in dut_a, NOP in dut_b
        issue(4'd12);
        tick();
        chk("or_a", ctl_a, M | ABUS | DRW | LDZ | 17'hE);
        chk("or_b", ctl_b, 0);
        tick();

        // every opcode single-stepped with random flags
        for (int op = 0; op < 16; op++) begin
            c = 1'($urandom);
            z = 1'($urandom);
            issue(4'(op));
            for (int k = 0; k < 5 && running_a; k++) tick();
            chk("sweep_done", running_a, 0);
        end

        // start held high restarts after a stepped NOP
        ir_a = 4'd0; start = 1'b1;
        tick(3);
        chk("step_nop_idle", running_a, 0);
        tick();
        chk("start_held_restart", w1_a, 1);
        start = 1'b0;
        tick(2);

        // step_en only matters at the last beat
        step_en = 1'b0;
        issue(4'd0);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        tick();
        chk("step_en_midbeat", w1_a, 1);
        step_en = 1'b1;
        tick(2);

        // free-running mixed program ending in STP
        begin
            int idx;
            step_en = 1'b0;
            issue(prog[0]);
            idx = 1;
            for (int k = 0; k < 40 && running_a; k++) begin
                tick();
                if (w1_a && idx < 6) begin
                    ir_a = prog[idx];
                    idx++;
                end
            end
            chk("prog_halt", running_a, 0);
            chk("prog_fetches", idx, 6);
        end

        // counter wrap in the 4-bit instance
        clr = 1'b0;
        tick();
        clr = 1'b1;
        step_en = 1'b0;
        issue(4'd0);
        tick(32);
        chk("wrap_b", icount_b, 0);
        chk("wrap_a", icount_a, 16);
        step_en = 1'b1;
        tick(2);
        chk("wrap_b_after", icount_b, 1);
        chk("wrap_idle", running_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
